// File: rtl/mux_demux_4ch_if.sv
// Bus bundle for the 4-channel mux/demux: mux inputs and select, demux
// input and select, the per-path enables, and all five registered outputs.
interface mux_demux_4ch_if #(
    parameter int WIDTH = 4
) ();

    // Mux path
    logic             mux_en;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] a3;
    logic [WIDTH-1:0] a4;
    logic [1:0]       mux_s;
    logic [WIDTH-1:0] d;

    // Demux path
    logic             demux_en;
    logic [WIDTH-1:0] a;
    logic [1:0]       demux_s;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [WIDTH-1:0] d4;

    // Producer of the routing requests, consumer of the routed outputs
    modport master (
        output mux_en, a1, a2, a3, a4, mux_s,
        output demux_en, a, demux_s,
        input  d, d1, d2, d3, d4
    );

    // The routing unit itself
    modport slave (
        input  mux_en, a1, a2, a3, a4, mux_s,
        input  demux_en, a, demux_s,
        output d, d1, d2, d3, d4
    );

endinterface

// File: rtl/mux_demux_4ch.sv
// Registered 4:1 multiplexer and 1:4 demultiplexer on independent paths.
// Each path captures on a rising clock edge when its enable is high and
// holds otherwise. All outputs come straight from flops, so there is no
// combinational route from any input to any output.
module mux_demux_4ch #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_demux_4ch_if.slave  bus
);

    logic [WIDTH-1:0] d_d,  d_q;
    logic [WIDTH-1:0] d1_d, d1_q;
    logic [WIDTH-1:0] d2_d, d2_q;
    logic [WIDTH-1:0] d3_d, d3_q;
    logic [WIDTH-1:0] d4_d, d4_q;

    // Mux next-state: pick the selected channel when enabled, otherwise hold.
    // An unknown select falls to the default arm, which drives X so the
    // problem stays visible in simulation instead of being masked.
    always_comb begin
        d_d = d_q;
        if (bus.mux_en) begin
            case (bus.mux_s)
                2'b00:   d_d = bus.a1;
                2'b01:   d_d = bus.a2;
                2'b10:   d_d = bus.a3;
                2'b11:   d_d = bus.a4;
                default: d_d = {WIDTH{1'bx}};
            endcase
        end else begin
            d_d = d_q;
        end
    end

    // Demux next-state: when enabled, clear all four lanes and steer the input
    // to the selected lane in the same edge; otherwise hold every lane.
    always_comb begin
        d1_d = d1_q;
        d2_d = d2_q;
        d3_d = d3_q;
        d4_d = d4_q;
        if (bus.demux_en) begin
            d1_d = {WIDTH{1'b0}};
            d2_d = {WIDTH{1'b0}};
            d3_d = {WIDTH{1'b0}};
            d4_d = {WIDTH{1'b0}};
            case (bus.demux_s)
                2'b00:   d1_d = bus.a;
                2'b01:   d2_d = bus.a;
                2'b10:   d3_d = bus.a;
                2'b11:   d4_d = bus.a;
                default: begin
                    d1_d = {WIDTH{1'bx}};
                    d2_d = {WIDTH{1'bx}};
                    d3_d = {WIDTH{1'bx}};
                    d4_d = {WIDTH{1'bx}};
                end
            endcase
        end else begin
            d1_d = d1_q;
            d2_d = d2_q;
            d3_d = d3_q;
            d4_d = d4_q;
        end
    end

    // Output registers; reset clears every lane immediately, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q  <= {WIDTH{1'b0}};
            d1_q <= {WIDTH{1'b0}};
            d2_q <= {WIDTH{1'b0}};
            d3_q <= {WIDTH{1'b0}};
            d4_q <= {WIDTH{1'b0}};
        end else begin
            d_q  <= d_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
            d3_q <= d3_d;
            d4_q <= d4_d;
        end
    end

    assign bus.d  = d_q;
    assign bus.d1 = d1_q;
    assign bus.d2 = d2_q;
    assign bus.d3 = d3_q;
    assign bus.d4 = d4_q;

endmodule

// File: tb/tb_mux_demux_4ch.sv
// Directed and randomised bench for mux_demux_4ch (WIDTH=4).
module tb_mux_demux_4ch;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mux_demux_4ch_if #(.WIDTH(W)) bus ();

    mux_demux_4ch #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_mux(input logic en, input logic [1:0] s,
                           input logic [W-1:0] x1, input logic [W-1:0] x2,
                           input logic [W-1:0] x3, input logic [W-1:0] x4);
        bus.mux_en = en;
        bus.mux_s  = s;
        bus.a1     = x1;
        bus.a2     = x2;
        bus.a3     = x3;
        bus.a4     = x4;
    endtask

    task automatic set_demux(input logic en, input logic [1:0] s, input logic [W-1:0] x);
        bus.demux_en = en;
        bus.demux_s  = s;
        bus.a        = x;
    endtask

    task automatic test_reset_initial();
        rst_n = 1'b1;
        set_mux(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
        set_demux(1'b0, 2'b00, 4'd0);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.d, bus.d1, bus.d2, bus.d3, bus.d4} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h expected %h",
                     {bus.d, bus.d1, bus.d2, bus.d3, bus.d4}, 20'h0);
        end
        // enables high during reset must not capture
        set_mux(1'b1, 2'b00, 4'd7, 4'd7, 4'd7, 4'd7);
        set_demux(1'b1, 2'b00, 4'd7);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.d, bus.d1, bus.d2, bus.d3, bus.d4} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_held: got %h expected %h",
                     {bus.d, bus.d1, bus.d2, bus.d3, bus.d4}, 20'h0);
        end
        @(negedge clk);
        set_mux(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
        set_demux(1'b0, 2'b00, 4'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_mux_sweep();
        logic [W-1:0] exp_tab [4] = '{4'd3, 4'd5, 4'd7, 4'd9};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_mux(1'b1, 2'(i), 4'(3 + i), 4'(4 + i), 4'(5 + i), 4'(6 + i));
            @(posedge clk);
            #1;
            vectors++;
            if (bus.d !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL mux_sweep s=%0d: got %0d expected %0d", i, bus.d, exp_tab[i]);
            end
        end
    endtask

    task automatic test_demux_sweep();
        logic [4*W-1:0] exp_tab [4] = '{16'h3000, 16'h0400, 16'h0050, 16'h0006};
        @(negedge clk);
        bus.mux_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_demux(1'b1, 2'(i), 4'(3 + i));
            @(posedge clk);
            #1;
            vectors++;
            if ({bus.d1, bus.d2, bus.d3, bus.d4} !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL demux_sweep s=%0d: got %h expected %h", i,
                         {bus.d1, bus.d2, bus.d3, bus.d4}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        set_mux(1'b0, 2'b00, 4'd15, 4'd15, 4'd15, 4'd15);
        set_demux(1'b0, 2'b00, 4'd15);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.d !== 4'd9) begin
                miscompares++;
                $display("FAIL mux_hold cyc=%0d: got %0d expected %0d", i, bus.d, 4'd9);
            end
            vectors++;
            if ({bus.d1, bus.d2, bus.d3, bus.d4} !== 16'h0006) begin
                miscompares++;
                $display("FAIL demux_hold cyc=%0d: got %h expected %h", i,
                         {bus.d1, bus.d2, bus.d3, bus.d4}, 16'h0006);
            end
            @(negedge clk);
            bus.mux_s   = 2'(i + 1);
            bus.demux_s = 2'(i + 1);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        set_mux(1'b1, 2'b01, 4'd15, 4'd5, 4'd15, 4'd15);
        #4;
        vectors++;
        if (bus.d !== 4'd9) begin
            miscompares++;
            $display("FAIL latency_before_edge: got %0d expected %0d", bus.d, 4'd9);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.d !== 4'd5) begin
            miscompares++;
            $display("FAIL latency_after_edge: got %0d expected %0d", bus.d, 4'd5);
        end
    endtask

    task automatic test_independence();
        @(negedge clk);
        set_mux(1'b1, 2'b10, 4'd1, 4'd2, 4'd10, 4'd4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_demux(i[0], 2'(i), 4'(i + 1));
            @(posedge clk);
            #1;
            vectors++;
            if (bus.d !== 4'd10) begin
                miscompares++;
                $display("FAIL independence cyc=%0d: got %0d expected %0d", i, bus.d, 4'd10);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_mux(1'b1, 2'b11, 4'd0, 4'd0, 4'd0, 4'd12);
        set_demux(1'b1, 2'b01, 4'd11);
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.d, bus.d1, bus.d2, bus.d3, bus.d4} !== 20'hC0B00) begin
            miscompares++;
            $display("FAIL both_enables_1: got %h expected %h",
                     {bus.d, bus.d1, bus.d2, bus.d3, bus.d4}, 20'hC0B00);
        end
        @(negedge clk);
        set_mux(1'b1, 2'b00, 4'd1, 4'd0, 4'd0, 4'd12);
        set_demux(1'b1, 2'b10, 4'd0);
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.d, bus.d1, bus.d2, bus.d3, bus.d4} !== 20'h10000) begin
            miscompares++;
            $display("FAIL both_enables_zero_data: got %h expected %h",
                     {bus.d, bus.d1, bus.d2, bus.d3, bus.d4}, 20'h10000);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_mux(1'b1, 2'b10, 4'd0, 4'd0, 4'd13, 4'd0);
        set_demux(1'b1, 2'b11, 4'd14);
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.d, bus.d1, bus.d2, bus.d3, bus.d4} !== 20'hD000E) begin
            miscompares++;
            $display("FAIL pre_reset_load: got %h expected %h",
                     {bus.d, bus.d1, bus.d2, bus.d3, bus.d4}, 20'hD000E);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.d, bus.d1, bus.d2, bus.d3, bus.d4} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_async_mid: got %h expected %h",
                     {bus.d, bus.d1, bus.d2, bus.d3, bus.d4}, 20'h0);
        end
        @(negedge clk);
        set_mux(1'b0, 2'b10, 4'd0, 4'd0, 4'd13, 4'd0);
        set_demux(1'b0, 2'b11, 4'd14);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.d, bus.d1, bus.d2, bus.d3, bus.d4} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_discards_hold: got %h expected %h",
                     {bus.d, bus.d1, bus.d2, bus.d3, bus.d4}, 20'h0);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ain [4];
        logic [W-1:0] m_d;
        logic [W-1:0] m_o [4];
        logic         men, den;
        logic [1:0]   ms, ds;
        logic [W-1:0] av;
        for (int k = 0; k < 4; k++) m_o[k] = 4'd0;
        m_d = 4'd0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) ain[k] = W'($urandom);
            men = (c == 0) ? 1'b1 : 1'($urandom);
            den = (c == 0) ? 1'b1 : 1'($urandom);
            ms  = 2'($urandom);
            ds  = 2'($urandom);
            av  = W'($urandom);
            set_mux(men, ms, ain[0], ain[1], ain[2], ain[3]);
            set_demux(den, ds, av);
            if (men) m_d = ain[ms];
            if (den) begin
                for (int k = 0; k < 4; k++) m_o[k] = (k == int'(ds)) ? av : 4'd0;
            end
            @(posedge clk);
            #1;
            vectors++;
            if ({bus.d, bus.d1, bus.d2, bus.d3, bus.d4} !== {m_d, m_o[0], m_o[1], m_o[2], m_o[3]}) begin
                miscompares++;
                $display("FAIL random cyc=%0d: got %h expected %h", c,
                         {bus.d, bus.d1, bus.d2, bus.d3, bus.d4},
                         {m_d, m_o[0], m_o[1], m_o[2], m_o[3]});
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset_initial();
        test_mux_sweep();
        test_demux_sweep();
        test_hold();
        test_latency();
        test_independence();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
